psum_accum_ctrl: RTL and testbench

- Parametrised successor to the per-column SFP accumulate path in core.
- Autonomously sequences a tile of output vectors: pop the OFIFO, read the matching PSUM SRAM entry, then add per column with signed saturation.
- Optionally applies ReLU, then writes the result back and streams it out.
- Sits between ofifo, PSUM_sram and the core output. It replaces per-cycle instruction-driven acc/passthrough/pmem bits with a start/done handshake.

---
 rtl/core_pkg.sv | 23 ++
 rtl/psum_lane_add.sv | 28 ++
 rtl/psum_accum_ctrl.sv | 163 ++++++++++++++++
 tb/tb_psum_accum_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the PSUM accumulate controller: FSM encoding,
// SRAM control polarities and the per-tile pass configuration.
package core_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_FETCH = 3'd2,
      ST_ACC   = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   localparam logic CEN_ON  = 1'b0;
   localparam logic CEN_OFF = 1'b1;
   localparam logic WEN_WR  = 1'b0;
   localparam logic WEN_RD  = 1'b1;

   typedef struct packed {
      logic first;
      logic relu;
   } pass_cfg_t;

endpackage

// File: rtl/psum_lane_add.sv
// One accumulate lane: signed add with one guard bit, saturation to the
// psum range, then optional ReLU. Purely combinational.
module psum_lane_add #(
   parameter int unsigned psum_bw = 16
) (
   input  logic signed [psum_bw-1:0] a,
   input  logic signed [psum_bw-1:0] b,
   input  logic                      relu,
   output logic signed [psum_bw-1:0] y
);

   localparam int unsigned SUM_W = psum_bw + 1;

   logic signed [SUM_W-1:0]   sum;
   logic signed [psum_bw-1:0] sat;

   always_comb begin
      sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      // guard bit disagreeing with the sign bit means the result left the range
      if (sum[SUM_W-1] != sum[SUM_W-2]) begin
         sat = sum[SUM_W-1] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
         sat = sum[psum_bw-1:0];
      end
      y = (relu && sat[psum_bw-1]) ? '0 : sat;
   end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Tile sequencer: pops OFIFO rows, reads/accumulates/writes back PSUM SRAM
// entries lane by lane, and streams each result with a start/done handshake.
module psum_accum_ctrl
   import core_pkg::*;
#(
   parameter int unsigned col     = 8,
   parameter int unsigned psum_bw = 16,
   parameter int unsigned addr_w  = 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [addr_w-1:0]        cfg_base,
   input  logic [addr_w:0]          cfg_count,
   input  logic                     cfg_first,
   input  logic                     cfg_relu,
   input  logic                     ofifo_valid,
   input  logic [col*psum_bw-1:0]   ofifo_out,
   output logic                     ofifo_rd,
   output logic                     CEN_pmem,
   output logic                     WEN_pmem,
   output logic [addr_w-1:0]        A_pmem,
   output logic [col*psum_bw-1:0]   D_pmem,
   input  logic [col*psum_bw-1:0]   Q_pmem,
   output logic [col*psum_bw-1:0]   sfp_out,
   output logic                     out_valid,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned VEC_W = col * psum_bw;
   localparam int unsigned CNT_W = addr_w + 1;

   state_t             state, state_n;
   logic [addr_w-1:0]  ptr, ptr_n;
   logic [CNT_W-1:0]   remaining, remaining_n;
   pass_cfg_t          pcfg, pcfg_n;

   logic               ofifo_rd_n, cen_n, wen_n, out_valid_n, busy_n, done_n;
   logic [addr_w-1:0]  a_n;
   logic [VEC_W-1:0]   d_n, sfp_n, sum_vec;

   // Per-lane datapath; the old value is forced to zero on a first pass
   for (genvar i = 0; i < col; i++) begin : g_lane
      logic [psum_bw-1:0] addend;
      assign addend = pcfg.first ? '0 : Q_pmem[i*psum_bw +: psum_bw];
      psum_lane_add #(.psum_bw(psum_bw)) u_lane (
         .a    (ofifo_out[i*psum_bw +: psum_bw]),
         .b    (addend),
         .relu (pcfg.relu),
         .y    (sum_vec[i*psum_bw +: psum_bw])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         remaining <= '0;
         pcfg      <= '0;
         ofifo_rd  <= 1'b0;
         CEN_pmem  <= CEN_OFF;
         WEN_pmem  <= WEN_RD;
         A_pmem    <= '0;
         D_pmem    <= '0;
         sfp_out   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         remaining <= remaining_n;
         pcfg      <= pcfg_n;
         ofifo_rd  <= ofifo_rd_n;
         CEN_pmem  <= cen_n;
         WEN_pmem  <= wen_n;
         A_pmem    <= a_n;
         D_pmem    <= d_n;
         sfp_out   <= sfp_n;
         out_valid <= out_valid_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

   always_comb begin
      state_n     = state;
      ptr_n       = ptr;
      remaining_n = remaining;
      pcfg_n      = pcfg;
      ofifo_rd_n  = 1'b0;
      cen_n       = CEN_OFF;
      wen_n       = WEN_RD;
      a_n         = A_pmem;
      d_n         = D_pmem;
      sfp_n       = sfp_out;
      out_valid_n = 1'b0;
      busy_n      = busy;
      done_n      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               pcfg_n.first = cfg_first;
               pcfg_n.relu  = cfg_relu;
               ptr_n        = cfg_base;
               remaining_n  = cfg_count;
               if (cfg_count == '0) begin
                  done_n = 1'b1;
                  busy_n = 1'b0;
               end else begin
                  state_n = ST_WAIT;
                  busy_n  = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (ofifo_valid) state_n = ST_FETCH;
         end
         ST_FETCH: state_n = ST_ACC;
         ST_ACC: begin
            d_n     = sum_vec;
            sfp_n   = sum_vec;
            state_n = ST_WRITE;
         end
         ST_WRITE: begin
            ptr_n       = ptr + addr_w'(1);
            remaining_n = remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else if (ofifo_valid) begin
               // a row is already waiting: skip WAIT to sustain 3 cycles/vector
               state_n = ST_FETCH;
            end else begin
               state_n = ST_WAIT;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // Registered strobes are decoded from the state being entered
      case (state_n)
         ST_FETCH: begin
            ofifo_rd_n = 1'b1;
            if (!pcfg_n.first) begin
               cen_n = CEN_ON;
               a_n   = ptr_n;
            end
         end
         ST_WRITE: begin
            cen_n       = CEN_ON;
            wen_n       = WEN_WR;
            a_n         = ptr_n;
            out_valid_n = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Randomised scoreboard bench for psum_accum_ctrl with OFIFO and SRAM models
// and an arithmetic reference of the accumulate/saturate/ReLU rules.
module tb_psum_accum_ctrl;

   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int AW    = 11;
   localparam int VEC_W = COL * BW;
   localparam int DEPTH = 1 << AW;
   localparam int BUF   = 8192;
   localparam int MAXV  = (1 << (BW - 1)) - 1;
   localparam int MINV  = -(1 << (BW - 1));

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [VEC_W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic [AW-1:0] cfg_base;
   logic [AW:0] cfg_count;
   logic cfg_first, cfg_relu;
   logic ofifo_valid = 1'b0;
   logic [VEC_W-1:0] ofifo_out = '0;
   logic ofifo_rd;
   logic CEN_pmem, WEN_pmem;
   logic [AW-1:0] A_pmem;
   logic [VEC_W-1:0] D_pmem, Q_pmem, sfp_out;
   logic out_valid, busy, done;

   logic [VEC_W-1:0] sram    [DEPTH];
   logic [VEC_W-1:0] ref_mem [DEPTH];
   logic [VEC_W-1:0] row_buf [BUF];
   int wr_idx = 0;
   int rd_idx = 0;
   logic ofifo_en;
   logic pre_we;
   logic [AW-1:0] pre_addr;
   logic [VEC_W-1:0] pre_data;

   exp_t exp_out[$];
   logic [AW-1:0] exp_rd[$];
   logic [VEC_W-1:0] dir_rows[$];

   int n_total = 0;
   int n_pass  = 0;

   psum_accum_ctrl #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_base(cfg_base), .cfg_count(cfg_count), .cfg_first(cfg_first), .cfg_relu(cfg_relu),
      .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
      .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem), .A_pmem(A_pmem), .D_pmem(D_pmem), .Q_pmem(Q_pmem),
      .sfp_out(sfp_out), .out_valid(out_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk_v(input string name, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   task automatic chk_i(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   function automatic logic [VEC_W-1:0] rand_row();
      logic [VEC_W-1:0] r;
      for (int i = 0; i < COL; i++) begin
         case ($urandom_range(0, 3))
            0:       r[i*BW +: BW] = BW'(MAXV - int'($urandom_range(0, 600)));
            1:       r[i*BW +: BW] = BW'(MINV + int'($urandom_range(0, 600)));
            default: r[i*BW +: BW] = BW'($urandom);
         endcase
      end
      return r;
   endfunction

   // Reference lane: integer add, clamp to the signed range, then ReLU
   function automatic logic [BW-1:0] ref_lane(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit relu);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
      if (relu && s < 0) s = 0;
      return BW'(s);
   endfunction

   // OFIFO model: pops half a cycle after the DUT raises ofifo_rd
   always @(negedge clk) begin
      #1;
      if (reset) rd_idx = wr_idx;
      else if (ofifo_rd && rd_idx != wr_idx) begin
         ofifo_out = row_buf[rd_idx % BUF];
         rd_idx++;
      end
      ofifo_valid = ofifo_en && (rd_idx != wr_idx);
   end

   // PSUM SRAM model with one-cycle read latency
   always @(posedge clk) begin
      if (pre_we) sram[pre_addr] <= pre_data;
      else if (CEN_pmem == 1'b0) begin
         if (WEN_pmem == 1'b0) sram[A_pmem] <= D_pmem;
         else Q_pmem <= sram[A_pmem];
      end
   end

   // Monitor: every DUT read, write and streamed vector is matched to the scoreboard
   always @(negedge clk) begin : monitor
      exp_t e;
      logic [AW-1:0] ra;
      if (!reset) begin
         if (out_valid) begin
            if (exp_out.size() == 0) chk_i("unexpected out_valid", 1, 0);
            else begin
               e = exp_out.pop_front();
               chk_v("sfp_out", sfp_out, e.data);
               chk_v("D_pmem", D_pmem, e.data);
               chk_i("write addr", int'(A_pmem), int'(e.addr));
               chk_i("write strobes", int'({CEN_pmem, WEN_pmem}), 0);
            end
         end else if (CEN_pmem == 1'b0 && WEN_pmem == 1'b0) begin
            chk_i("write without out_valid", 1, 0);
         end
         if (CEN_pmem == 1'b0 && WEN_pmem == 1'b1) begin
            if (exp_rd.size() == 0) chk_i("unexpected SRAM read", 1, 0);
            else begin
               ra = exp_rd.pop_front();
               chk_i("read addr", int'(A_pmem), int'(ra));
            end
         end
         if (ofifo_rd) chk_i("pop with row pending", int'(rd_idx != wr_idx), 1);
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk_i({tag, " ctrl"}, int'({ofifo_rd, CEN_pmem, WEN_pmem, out_valid, busy, done}), 6'b011000);
      chk_i({tag, " A_pmem"}, int'(A_pmem), 0);
      chk_v({tag, " D_pmem"}, D_pmem, '0);
      chk_v({tag, " sfp_out"}, sfp_out, '0);
   endtask

   task automatic preload(input int addr, input logic [VEC_W-1:0] data);
      pre_we = 1'b1; pre_addr = AW'(addr); pre_data = data;
      ref_mem[addr] = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic run_tile(input int base, input int count, input bit first, input bit relu,
                           input bit stall, input bit busy_start);
      logic [VEC_W-1:0] row, old, res;
      int addr, cyc, nv, last_wr, first_wr, n_rd, stall_act;
      bit got_done;
      for (int k = 0; k < count; k++) begin
         row = (dir_rows.size() != 0) ? dir_rows.pop_front() : rand_row();
         row_buf[wr_idx % BUF] = row;
         wr_idx++;
         addr = (base + k) % DEPTH;
         old  = first ? '0 : ref_mem[addr];
         for (int i = 0; i < COL; i++) res[i*BW +: BW] = ref_lane(row[i*BW +: BW], old[i*BW +: BW], relu);
         ref_mem[addr] = res;
         exp_out.push_back('{addr: AW'(addr), data: res});
         if (!first) exp_rd.push_back(AW'(addr));
      end
      cfg_base = AW'(base); cfg_count = (AW+1)'(count); cfg_first = first; cfg_relu = relu;
      start = 1'b1;
      cyc = 0; nv = 0; last_wr = 0; first_wr = 0; n_rd = 0; stall_act = 0; got_done = 0;
      while (!got_done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            chk_i("busy after start", int'(busy), int'(count > 0));
         end
         if (busy_start && cyc == 3) begin
            start = 1'b1; cfg_base = AW'(base + 100); cfg_count = 5; cfg_first = ~first; cfg_relu = ~relu;
         end
         if (busy_start && cyc == 4) start = 1'b0;
         if (ofifo_rd) n_rd++;
         if (out_valid) begin
            nv++;
            last_wr = cyc;
            if (nv == 1) first_wr = cyc;
         end
         if (done) got_done = 1;
         else if (stall && out_valid && nv < count) begin
            ofifo_en = 1'b0;
            repeat (10) begin
               @(negedge clk);
               cyc++;
               if (CEN_pmem == 1'b0 || ofifo_rd) stall_act++;
            end
            ofifo_en = 1'b1;
         end
      end
      chk_i("done seen", int'(got_done), 1);
      chk_i("busy at done", int'(busy), 0);
      if (count == 0) begin
         chk_i("count0 done latency", cyc, 1);
         chk_i("count0 no pop", n_rd, 0);
      end else begin
         chk_i("vectors streamed", nv, count);
         chk_i("pops", n_rd, count);
         chk_i("first write latency", first_wr, 4);
         chk_i("done after last write", cyc - last_wr, 1);
         if (stall) chk_i("stall SRAM/OFIFO idle", stall_act, 0);
      end
      chk_i("scoreboard drained", exp_out.size() + exp_rd.size(), 0);
      exp_out.delete();
      exp_rd.delete();
      @(negedge clk);
      chk_i("done pulse width", int'(done), 0);
   endtask

   initial begin
      logic [VEC_W-1:0] pre, row;
      bit found;
      reset = 1'b1; start = 1'b0; cfg_base = '0; cfg_count = '0; cfg_first = 1'b0; cfg_relu = 1'b0;
      ofifo_en = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      for (int a = 0; a < DEPTH; a++) preload(a, rand_row());
      reset = 1'b0;
      @(negedge clk);

      // first pass: no SRAM reads, lane0 carries 1..4
      for (int k = 1; k <= 4; k++) begin
         row = rand_row(); row[BW-1:0] = BW'(k); dir_rows.push_back(row);
      end
      run_tile(0, 4, 1, 0, 0, 0);
      chk_i("first pass last lane0", int'(sfp_out[BW-1:0]), 4);

      // accumulate 100 + (-30)
      pre = rand_row(); pre[BW-1:0] = 16'd100; preload(5, pre);
      row = rand_row(); row[BW-1:0] = 16'hFFE2; dir_rows.push_back(row);
      run_tile(5, 1, 0, 0, 0, 0);
      chk_i("accumulate lane0", int'(sfp_out[BW-1:0]), 70);

      // saturation in both directions, with and without ReLU
      pre = rand_row(); pre[BW-1:0] = 16'd32000; pre[2*BW-1:BW] = 16'h8300;
      row = rand_row(); row[BW-1:0] = 16'd1000;  row[2*BW-1:BW] = 16'hFC18;
      preload(6, pre); dir_rows.push_back(row);
      run_tile(6, 1, 0, 1, 0, 0);
      chk_i("sat+ lane0", int'(sfp_out[BW-1:0]), 16'h7FFF);
      chk_i("relu lane1", int'(sfp_out[2*BW-1:BW]), 0);
      preload(7, pre); dir_rows.push_back(row);
      run_tile(7, 1, 0, 0, 0, 0);
      chk_i("sat- lane1", int'(sfp_out[2*BW-1:BW]), 16'h8000);

      // stall between rows and address wrap
      run_tile(DEPTH - 1, 2, 0, 0, 1, 0);
      chk_i("wrap last addr", int'(A_pmem), 0);

      // boundaries
      run_tile(33, 0, 0, 0, 0, 0);
      run_tile(40, 3, 0, 1, 0, 1);

      // reset during ACC aborts the pending write
      pre = rand_row(); preload(9, pre);
      row_buf[wr_idx % BUF] = rand_row(); wr_idx++;
      exp_rd.push_back(AW'(9));
      cfg_base = 9; cfg_count = 1; cfg_first = 1'b0; cfg_relu = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (ofifo_rd) found = 1;
         else @(negedge clk);
      end
      chk_i("reached fetch", int'(found), 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid-tile reset");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_v("no write after reset", sram[9], pre);
      chk_i("abort read consumed", exp_rd.size(), 0);
      exp_rd.delete();
      run_tile(9, 2, 0, 1, 0, 0);

      // randomised tiles
      for (int t = 0; t < 8; t++) begin
         run_tile(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 6)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
